// File: rtl/judge_scheduler.sv
// judge_scheduler: one-deep per-track judgment buffers serialized round-robin onto a
// single valid/ready output. Define JUDGE_LOST_PRIORITY_EN to let lost judgments win arbitration.
module judge_scheduler #(
    parameter int NTRACK = 6
) (
    input  logic                  OriginalClk,
    input  logic                  ResetN,
    input  logic [NTRACK-1:0]     TrackValid,
    input  logic [3*NTRACK-1:0]   TrackMsg,
    input  logic                  JudgeReady,
    output logic                  JudgeValid,
    output logic [2:0]            JudgeMsg,
    output logic [2:0]            JudgeTrack,
    input  logic                  OverflowClr,
    output logic [NTRACK-1:0]     Overflow,
    output logic                  Busy
);

    localparam int PW = (NTRACK > 1) ? $clog2(NTRACK) : 1;
    localparam logic [PW-1:0] LAST_TRACK = PW'(NTRACK - 1);

    logic [NTRACK-1:0]   slot_valid;
    logic [NTRACK-1:0]   slot_valid_nxt;
    logic [2*NTRACK-1:0] slot_code;
    logic [2*NTRACK-1:0] slot_code_nxt;
    logic [PW-1:0]       rr_ptr;
    logic                out_free;
    logic                grant_en;
    logic [PW-1:0]       grant_idx;
    logic [1:0]          grant_code;
    logic [NTRACK-1:0]   grant_hot;
    logic [NTRACK-1:0]   ovf_set;
    logic [PW:0]         pick_all;
    logic [PW:0]         pick_sel;

    // Returns {found, index} of the first set mask bit searching upward from ptr+1 with wrap.
    function automatic logic [PW:0] rr_pick(input logic [NTRACK-1:0] mask,
                                            input logic [PW-1:0]     ptr);
        logic [PW:0] result;
        int          cand;
        result = '0;
        for (int i = NTRACK - 1; i >= 0; i--) begin
            cand = (int'(ptr) + 1 + i) % NTRACK;
            if (mask[PW'(cand)]) begin
                result = {1'b1, PW'(cand)};
            end
        end
        return result;
    endfunction

    assign out_free = !JudgeValid || JudgeReady;
    assign pick_all = rr_pick(slot_valid, rr_ptr);

`ifdef JUDGE_LOST_PRIORITY_EN
    logic [NTRACK-1:0] lost_mask;
    logic [PW:0]       pick_lost;

    always_comb begin
        lost_mask = '0;
        for (int t = 0; t < NTRACK; t++) begin
            lost_mask[t] = slot_valid[t] && (slot_code[2*t +: 2] == 2'd1);
        end
    end

    assign pick_lost = rr_pick(lost_mask, rr_ptr);
    assign pick_sel  = pick_lost[PW] ? pick_lost : pick_all;
`else
    assign pick_sel  = pick_all;
`endif

    assign grant_en  = out_free && pick_sel[PW];
    assign grant_idx = pick_sel[PW-1:0];

    always_comb begin
        grant_hot  = '0;
        grant_code = slot_code[2*grant_idx +: 2];
        if (grant_en) begin
            grant_hot[grant_idx] = 1'b1;
        end
    end

    // A slot granted this cycle counts as empty, so a same-cycle arrival refills it.
    always_comb begin
        slot_valid_nxt = slot_valid & ~grant_hot;
        slot_code_nxt  = slot_code;
        ovf_set        = '0;
        for (int t = 0; t < NTRACK; t++) begin
            if (TrackValid[t] && (TrackMsg[3*t +: 3] != 3'd0)) begin
                if (!slot_valid[t] || grant_hot[t]) begin
                    slot_valid_nxt[t]       = 1'b1;
                    slot_code_nxt[2*t +: 2] = TrackMsg[3*t+2] ? 2'd1 : TrackMsg[3*t +: 2];
                end else begin
                    ovf_set[t] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge OriginalClk or negedge ResetN) begin
        if (!ResetN) begin
            slot_valid <= '0;
            slot_code  <= '0;
        end else begin
            slot_valid <= slot_valid_nxt;
            slot_code  <= slot_code_nxt;
        end
    end

    // Pointer starts at the last track so that track 0 is searched first after reset.
    always_ff @(posedge OriginalClk or negedge ResetN) begin
        if (!ResetN) begin
            rr_ptr     <= LAST_TRACK;
            JudgeValid <= 1'b0;
            JudgeMsg   <= 3'd0;
            JudgeTrack <= 3'd0;
        end else if (grant_en) begin
            rr_ptr     <= grant_idx;
            JudgeValid <= 1'b1;
            JudgeMsg   <= {1'b0, grant_code};
            JudgeTrack <= 3'(grant_idx);
        end else if (JudgeReady) begin
            JudgeValid <= 1'b0;
        end
    end

    always_ff @(posedge OriginalClk or negedge ResetN) begin
        if (!ResetN) begin
            Overflow <= '0;
        end else if (OverflowClr) begin
            Overflow <= '0;
        end else begin
            Overflow <= Overflow | ovf_set;
        end
    end

    assign Busy = JudgeValid || (|slot_valid);

endmodule

// File: doc/judge_scheduler.md
JUDGE_SCHEDULER -- requirements
Module: judge_scheduler

Interface
REQ-001 SHALL provide parameter NTRACK, default 6, number of judgment requesters (tracks).
REQ-002 SHALL provide port OriginalClk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL provide port ResetN  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port TrackValid  input  NTRACK  per-track judgment strobe, one cycle per event.
REQ-005 SHALL provide port TrackMsg  input  3*NTRACK  per-track judgment, bits [3t+2:3t] for track t; 0 not_in_zone, 1 lost, 2 far, 3 pure.
REQ-006 SHALL provide port JudgeReady  input  1  downstream combo/score logic accepts JudgeMsg this cycle.
REQ-007 SHALL provide port JudgeValid  output  1  JudgeMsg/JudgeTrack hold a judgment.
REQ-008 SHALL provide port JudgeMsg  output  3  serialized judgment code, 1..3 only.
REQ-009 SHALL provide port JudgeTrack  output  3  index of the originating track.
REQ-010 SHALL provide port OverflowClr  input  1  clears all Overflow bits when high.
REQ-011 SHALL provide port Overflow  output  NTRACK  sticky per-track drop flag.
REQ-012 SHALL provide port Busy  output  1  high when any pending slot is full or JudgeValid is high.

Function
REQ-013 SHALL hold one pending slot per track (valid bit + 2-bit code).
REQ-014 SHALL capture on TrackValid[t] with TrackMsg code 1..3; code 0 SHALL be ignored; codes 4..7 SHALL be captured as lost (1).
REQ-015 SHALL treat the output register as free when JudgeValid=0 or JudgeReady=1 (transfer = JudgeValid & JudgeReady).
REQ-016 SHALL, when the output register is free and any slot is pending, grant exactly one slot per cycle and load JudgeValid=1, JudgeMsg, JudgeTrack at that edge; the granted slot empties at the same edge.
REQ-017 SHALL arbitrate round-robin: search starts at (last granted + 1) mod NTRACK; pointer updates only on grant.
REQ-018 SHALL hold JudgeValid/JudgeMsg/JudgeTrack stable while JudgeValid=1 and JudgeReady=0.
REQ-019 SHALL clear JudgeValid at the edge of a transfer when no slot is pending.
REQ-020 SHALL give minimum latency 2 edges: capture at edge k, JudgeValid=1 after edge k+1.
REQ-021 SHALL, if slot t is granted and TrackValid[t] arrives in the same cycle, capture the new judgment into the freed slot.
REQ-022 SHALL, if slot t is full, not granted, and a valid judgment arrives, keep the old entry, drop the new one, and set Overflow[t].
REQ-023 SHALL give OverflowClr priority over a same-cycle set (clear wins).
REQ-024 SHALL never output code 0 and never emit a judgment twice.

Reset
REQ-025 SHALL, on ResetN low, asynchronously clear all slots, JudgeValid=0, JudgeMsg=0, JudgeTrack=0, Overflow=0, Busy=0, and round-robin pointer=NTRACK-1 (track 0 first).
REQ-026 SHALL discard all pending and in-flight judgments on reset mid-operation; first grant after release comes from track 0 search order.

Configuration
REQ-027 SHALL honour macro JUDGE_LOST_PRIORITY_EN: when defined, pending lost slots win over far/pure slots, round-robin within each class; when undefined, pure round-robin regardless of code.

Verification
REQ-028 Single event: TrackValid=000100, track2 msg=3, JudgeReady=1 -> JudgeValid=1, JudgeMsg=3, JudgeTrack=2 two edges later, for one cycle.
REQ-029 All six valid same cycle (msgs 1,2,3,1,2,3), JudgeReady=1 -> JudgeTrack 0,1,2,3,4,5 on six consecutive cycles, no Overflow.
REQ-030 Backpressure: JudgeReady=0 for 5 cycles with track1 pending, then track1 fires again -> output held stable, Overflow[1]=1, second judgment dropped; OverflowClr -> Overflow=0.
REQ-031 Filtering: track3 msg=0 -> no output; track3 msg=6 -> JudgeMsg=1.
REQ-032 With JUDGE_LOST_PRIORITY_EN: tracks 0 (pure) and 4 (lost) pending, pointer=5 -> track4 granted first; without macro -> track0 first.
REQ-033 ResetN pulsed low while JudgeValid=1 and three slots pending -> all outputs 0 immediately, no judgments emitted after release.
